axi_wr_burst_engine: RTL and testbench

//  Parametrised AXI4 write-slave protocol engine (AW/W/B) and successor to the single-transaction
//  AXI FSM model. Queues up to OUTSTANDING write addresses and generates per-beat addresses for

---
 rtl/axi_pkg.sv | 39 +++
 rtl/axi_aw_queue.sv | 51 +++++
 rtl/axi_wr_burst_engine.sv | 153 +++++++++++++++
 tb/tb_axi_wr_burst_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI write-engine definitions: burst/response codes, W FSM encoding
// and the per-beat address generator.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Address arithmetic is done at this width and truncated by the caller.
    localparam int ADDR_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_RESP  = 2'd2
    } wr_state_t;

    function automatic logic [ADDR_MAX-1:0] next_addr(
        input logic [ADDR_MAX-1:0] cur,
        input logic [2:0]          size,
        input logic [7:0]          len,
        input logic [1:0]          burst
    );
        logic [ADDR_MAX-1:0] nb;
        logic [ADDR_MAX-1:0] wb;
        nb = ADDR_MAX'(1) << size;
        wb = nb * (ADDR_MAX'(len) + ADDR_MAX'(1));
        case (burst)
            BURST_INCR: next_addr = (cur & ~(nb - ADDR_MAX'(1))) + nb;
            BURST_WRAP: next_addr = (cur & ~(wb - ADDR_MAX'(1))) |
                                    ((cur + nb) & (wb - ADDR_MAX'(1)));
            default:    next_addr = cur;
        endcase
    endfunction

endpackage

// File: rtl/axi_aw_queue.sv
// Synchronous FIFO holding queued write-address commands {addr,len,size,burst}.
module axi_aw_queue #(
    parameter  int EW    = 45,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [EW-1:0] push_data,
    input  logic          pop,
    output logic [EW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [EW-1:0] entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_wr_burst_engine.sv
// AXI4 write slave: queues AW commands, walks FIXED/INCR/WRAP bursts onto a
// byte-strobed memory port and returns one B response per burst.
module axi_wr_burst_engine
    import axi_pkg::*;
#(
    parameter  int AW          = 32,
    parameter  int DW          = 64,
    parameter  int OUTSTANDING = 4,
    localparam int SW          = DW / 8,
    localparam int CW          = $clog2(OUTSTANDING + 1)
) (
    input  logic          axi_aclk,
    input  logic          rst,
    input  logic [AW-1:0] s_awaddr,
    input  logic [7:0]    s_awlen,
    input  logic [2:0]    s_awsize,
    input  logic [1:0]    s_awburst,
    input  logic          s_awvalid,
    output logic          s_awready,
    input  logic [DW-1:0] s_wdata,
    input  logic [SW-1:0] s_wstrb,
    input  logic          s_wlast,
    input  logic          s_wvalid,
    output logic          s_wready,
    output logic [1:0]    s_bresp,
    output logic          s_bvalid,
    input  logic          s_bready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [SW-1:0] mem_wstrb,
    output logic [CW-1:0] outstanding
);
    localparam int EW     = AW + 13;
    localparam int SZ_MAX = $clog2(SW);

    wr_state_t     state, state_n;
    logic [EW-1:0] head;
    logic [AW-1:0] head_addr;
    logic [7:0]    head_len;
    logic [2:0]    head_size;
    logic [1:0]    head_burst;
    logic          head_illegal;
    logic          q_full, q_empty, pop;

    logic [AW-1:0] cur_addr;
    logic [7:0]    beat_cnt, len_q;
    logic [2:0]    size_q;
    logic [1:0]    burst_q;
    logic          err;
    logic          w_hs, beat_last, wlast_bad;

    axi_aw_queue #(.EW(EW), .DEPTH(OUTSTANDING)) u_aw_queue (
        .clk       (axi_aclk),
        .rst       (rst),
        .push      (s_awvalid && s_awready),
        .push_data ({s_awaddr, s_awlen, s_awsize, s_awburst}),
        .pop       (pop),
        .pop_data  (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (outstanding)
    );

    assign s_awready = !q_full;
    assign {head_addr, head_len, head_size, head_burst} = head;

    // Legality is judged once, on the command as it leaves the queue.
    always_comb begin
        head_illegal = 1'b0;
        if (int'(head_size) > SZ_MAX) head_illegal = 1'b1;
        if (head_burst == 2'b11)      head_illegal = 1'b1;
        if (head_burst == BURST_WRAP) begin
            if (!(head_len inside {8'd1, 8'd3, 8'd7, 8'd15})) head_illegal = 1'b1;
            if ((head_addr & ((AW'(1) << head_size) - AW'(1))) != '0) head_illegal = 1'b1;
        end
    end

    assign beat_last = (beat_cnt == len_q);
    assign w_hs      = s_wvalid && s_wready;
    assign wlast_bad = (s_wlast != beat_last);

    always_ff @(posedge axi_aclk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        s_wready = 1'b0;
        s_bvalid = 1'b0;
        s_bresp  = RESP_OKAY;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    state_n = ST_BURST;
                end
            end
            ST_BURST: begin
                s_wready = 1'b1;
                if (s_wvalid && beat_last) state_n = ST_RESP;
            end
            ST_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = err ? RESP_SLVERR : RESP_OKAY;
                if (s_bready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            cur_addr  <= '0;
            beat_cnt  <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            if (pop) begin
                cur_addr <= head_addr;
                len_q    <= head_len;
                size_q   <= head_size;
                burst_q  <= head_burst;
                beat_cnt <= '0;
                err      <= head_illegal;
            end
            if (w_hs) begin
                // The beat carrying a WLAST mismatch is itself suppressed.
                if (!err && !wlast_bad) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= cur_addr;
                    mem_wdata <= s_wdata;
                    mem_wstrb <= s_wstrb;
                end
                if (wlast_bad) err <= 1'b1;
                if (!beat_last) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    cur_addr <= AW'(next_addr(ADDR_MAX'(cur_addr), size_q, len_q, burst_q));
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Directed bench for axi_wr_burst_engine: burst address walks, queueing,
// legality errors, B back-pressure and mid-burst reset.
module tb_axi_wr_burst_engine;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic [AW-1:0] s_awaddr;
    logic [7:0]    s_awlen;
    logic [2:0]    s_awsize;
    logic [1:0]    s_awburst;
    logic          s_awvalid, s_awready;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          s_wlast, s_wvalid, s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid, s_bready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [CW-1:0] outstanding;

    int checks = 0;
    int passes = 0;

    logic [AW-1:0] ma[$];
    logic [DW-1:0] md[$];
    logic [SW-1:0] ms[$];
    logic [1:0]    bq[$];

    axi_wr_burst_engine #(.AW(AW), .DW(DW), .OUTSTANDING(4)) dut (
        .axi_aclk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && mem_we) begin
            ma.push_back(mem_addr);
            md.push_back(mem_wdata);
            ms.push_back(mem_wstrb);
        end
        if (!rst && s_bvalid && s_bready) bq.push_back(s_bresp);
    end

    task automatic clear_mon();
        ma.delete(); md.delete(); ms.delete(); bq.delete();
    endtask

    task automatic aw_send(input logic [AW-1:0] a, input logic [7:0] l,
                           input logic [2:0] sz, input logic [1:0] b);
        int n;
        @(negedge clk);
        s_awaddr = a; s_awlen = l; s_awsize = sz; s_awburst = b; s_awvalid = 1'b1;
        n = 0;
        while (!s_awready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin checks++; $display("FAIL aw_timeout: awready=%b required 1", s_awready); end
        @(negedge clk);
        s_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] st, input logic last);
        int n;
        @(negedge clk);
        s_wdata = d; s_wstrb = st; s_wlast = last; s_wvalid = 1'b1;
        n = 0;
        while (!s_wready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin checks++; $display("FAIL w_timeout: wready=%b required 1", s_wready); end
        @(negedge clk);
        s_wvalid = 1'b0;
    endtask

    task automatic run_burst(input logic [AW-1:0] a, input logic [7:0] l,
                             input logic [2:0] sz, input logic [1:0] b);
        aw_send(a, l, sz, b);
        for (int i = 0; i <= int'(l); i++)
            w_send({a, 32'(i)}, ~8'(i), (i == int'(l)));
    endtask

    task automatic wait_b(input int n);
        int k;
        k = 0;
        while (bq.size() < n && k < 500) begin @(negedge clk); k++; end
        if (bq.size() < n) begin
            checks++;
            $display("FAIL b_timeout: responses=%0d required %0d", bq.size(), n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (s_awready !== 1'b1) $display("FAIL rst_awready: got %b want 1", s_awready); else passes++;
        checks++; if (s_wready !== 1'b0) $display("FAIL rst_wready: got %b want 0", s_wready); else passes++;
        checks++; if (s_bvalid !== 1'b0 || s_bresp !== 2'b00) $display("FAIL rst_b: got v=%b r=%b want 0/00", s_bvalid, s_bresp); else passes++;
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== '0)
            $display("FAIL rst_mem: got we=%b a=%h d=%h s=%h want zeros", mem_we, mem_addr, mem_wdata, mem_wstrb); else passes++;
        checks++; if (outstanding !== 3'd0) $display("FAIL rst_outstanding: got %0d want 0", outstanding); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_incr();
        logic [AW-1:0] exp_a [4];
        exp_a = '{32'h100, 32'h108, 32'h110, 32'h118};
        clear_mon();
        run_burst(32'h100, 8'd3, 3'd3, 2'b01);
        wait_b(1);
        checks++; if (ma.size() != 4) $display("FAIL incr_count: got %0d want 4", ma.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ma[i] !== exp_a[i]) $display("FAIL incr_addr%0d: got %h want %h", i, ma[i], exp_a[i]); else passes++;
        end
        checks++; if (md[2] !== 64'h0000_0100_0000_0002) $display("FAIL incr_data: got %h want 0000010000000002", md[2]); else passes++;
        checks++; if (ms[2] !== 8'hFD) $display("FAIL incr_strb: got %h want fd", ms[2]); else passes++;
        checks++; if (bq[0] !== 2'b00) $display("FAIL incr_bresp: got %b want 00", bq[0]); else passes++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a = '{32'h118, 32'h100, 32'h108, 32'h110};
        clear_mon();
        run_burst(32'h118, 8'd3, 3'd3, 2'b10);
        wait_b(1);
        checks++; if (ma.size() != 4) $display("FAIL wrap_count: got %0d want 4", ma.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ma[i] !== exp_a[i]) $display("FAIL wrap_addr%0d: got %h want %h", i, ma[i], exp_a[i]); else passes++;
        end
        checks++; if (bq[0] !== 2'b00) $display("FAIL wrap_bresp: got %b want 00", bq[0]); else passes++;
    endtask

    task automatic test_fixed_unaligned();
        logic [AW-1:0] exp_u [3];
        exp_u = '{32'h103, 32'h104, 32'h108};
        clear_mon();
        run_burst(32'h40, 8'd2, 3'd3, 2'b00);
        wait_b(1);
        checks++; if (ma.size() != 3) $display("FAIL fixed_count: got %0d want 3", ma.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ma[i] !== 32'h40) $display("FAIL fixed_addr%0d: got %h want 40", i, ma[i]); else passes++;
        end
        clear_mon();
        run_burst(32'h103, 8'd2, 3'd2, 2'b01);
        wait_b(1);
        checks++; if (ma.size() != 3) $display("FAIL unal_count: got %0d want 3", ma.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ma[i] !== exp_u[i]) $display("FAIL unal_addr%0d: got %h want %h", i, ma[i], exp_u[i]); else passes++;
        end
    endtask

    task automatic test_queue();
        logic [AW-1:0] exp_a [5];
        logic [1:0]    exp_b [6];
        exp_a = '{32'h200, 32'h210, 32'h230, 32'h240, 32'h250};
        exp_b = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        clear_mon();
        // First command is popped into the active burst, the next four fill the queue.
        for (int k = 0; k < 5; k++)
            aw_send(32'h200 + 32'(k * 16), 8'd0, 3'd3, (k == 2) ? 2'b11 : 2'b01);
        @(negedge clk);
        checks++; if (outstanding !== 3'd4) $display("FAIL q_full_count: got %0d want 4", outstanding); else passes++;
        checks++; if (s_awready !== 1'b0) $display("FAIL q_full_awready: got %b want 0", s_awready); else passes++;
        s_awaddr = 32'h250; s_awlen = 8'd0; s_awsize = 3'd3; s_awburst = 2'b01; s_awvalid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (s_awready !== 1'b0 || outstanding !== 3'd4)
            $display("FAIL q_stall: got awready=%b count=%0d want 0/4", s_awready, outstanding); else passes++;
        fork
            begin
                int n;
                n = 0;
                while (!s_awready && n < 500) begin @(negedge clk); n++; end
                if (n >= 500) begin checks++; $display("FAIL q_aw6_timeout: awready=%b required 1", s_awready); end
                @(negedge clk);
                s_awvalid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) w_send(64'(k), 8'hFF, 1'b1);
            end
        join
        wait_b(6);
        checks++; if (ma.size() != 5) $display("FAIL q_mem_count: got %0d want 5", ma.size()); else passes++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ma[i] !== exp_a[i]) $display("FAIL q_addr%0d: got %h want %h", i, ma[i], exp_a[i]); else passes++;
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (bq[i] !== exp_b[i]) $display("FAIL q_bresp%0d: got %b want %b", i, bq[i], exp_b[i]); else passes++;
        end
    endtask

    task automatic test_errors();
        logic [AW-1:0] ea [4];
        logic [7:0]    el [4];
        logic [2:0]    es [4];
        logic [1:0]    eb [4];
        ea = '{32'h300, 32'h300, 32'h300, 32'h304};
        el = '{8'd1, 8'd2, 8'd0, 8'd1};
        es = '{3'd3, 3'd3, 3'd4, 3'd3};
        eb = '{2'b11, 2'b10, 2'b01, 2'b10};
        for (int c = 0; c < 4; c++) begin
            clear_mon();
            run_burst(ea[c], el[c], es[c], eb[c]);
            wait_b(1);
            checks++; if (ma.size() != 0) $display("FAIL err%0d_mem: got %0d pulses want 0", c, ma.size()); else passes++;
            checks++; if (bq[0] !== 2'b10) $display("FAIL err%0d_bresp: got %b want 10", c, bq[0]); else passes++;
        end
        clear_mon();
        aw_send(32'h400, 8'd3, 3'd3, 2'b01);
        w_send(64'hA0, 8'hFF, 1'b0);
        w_send(64'hA1, 8'hFF, 1'b1);
        w_send(64'hA2, 8'hFF, 1'b0);
        w_send(64'hA3, 8'hFF, 1'b1);
        wait_b(1);
        checks++; if (ma.size() != 1) $display("FAIL wlast_mem_count: got %0d want 1", ma.size()); else passes++;
        checks++; if (ma[0] !== 32'h400) $display("FAIL wlast_addr: got %h want 400", ma[0]); else passes++;
        checks++; if (bq[0] !== 2'b10) $display("FAIL wlast_bresp: got %b want 10", bq[0]); else passes++;
    endtask

    task automatic test_bhold_reset();
        int k, bad;
        clear_mon();
        s_bready = 1'b0;
        aw_send(32'h500, 8'd0, 3'd3, 2'b01);
        w_send(64'h55, 8'hFF, 1'b1);
        k = 0;
        while (!s_bvalid && k < 100) begin @(negedge clk); k++; end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!s_bvalid || s_wready || s_bresp !== 2'b00) bad++;
        end
        checks++; if (bad != 0) $display("FAIL bhold: got %0d bad cycles want 0", bad); else passes++;
        s_bready = 1'b1;
        wait_b(1);
        checks++; if (bq.size() != 1 || ma[0] !== 32'h500)
            $display("FAIL bhold_done: got nb=%0d a=%h want 1/500", bq.size(), ma[0]); else passes++;

        aw_send(32'h600, 8'd3, 3'd3, 2'b01);
        aw_send(32'h700, 8'd0, 3'd3, 2'b01);
        aw_send(32'h800, 8'd0, 3'd3, 2'b01);
        w_send(64'h60, 8'hFF, 1'b0);
        checks++; if (outstanding !== 3'd2) $display("FAIL pre_rst_count: got %0d want 2", outstanding); else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (outstanding !== 3'd0 || s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b0)
            $display("FAIL mid_rst: got cnt=%0d bv=%b awr=%b wr=%b want 0/0/1/0", outstanding, s_bvalid, s_awready, s_wready); else passes++;
        rst = 1'b0;
        clear_mon();
        repeat (20) @(negedge clk);
        checks++; if (bq.size() != 0 || ma.size() != 0)
            $display("FAIL post_rst_quiet: got b=%0d mem=%0d want 0/0", bq.size(), ma.size()); else passes++;
        run_burst(32'h900, 8'd0, 3'd3, 2'b01);
        wait_b(1);
        checks++; if (ma.size() != 1 || ma[0] !== 32'h900 || bq[0] !== 2'b00)
            $display("FAIL post_rst_burst: got n=%0d a=%h r=%b want 1/900/00", ma.size(), ma[0], bq[0]); else passes++;
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_unaligned();
        test_queue();
        test_errors();
        test_bhold_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
